// File: rtl/alu_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl_pkg
// Brief    : Shared ALU opcodes, data-width defaults and sequencer FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_ctrl_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_OP_W  = 5;

  localparam logic [DEF_OP_W-1:0] ALU_ADD = 5'd0;
  localparam logic [DEF_OP_W-1:0] ALU_SUB = 5'd1;
  localparam logic [DEF_OP_W-1:0] ALU_AND = 5'd2;
  localparam logic [DEF_OP_W-1:0] ALU_OR  = 5'd3;
  localparam logic [DEF_OP_W-1:0] ALU_XOR = 5'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage : alu_seq_ctrl_pkg
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Brief    : Drives an external combinational ALU to produce term n of the
//            recurrence t(k) = t(k-1) OP t(k-2), returned with a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OP_W  = DEF_OP_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [OP_W-1:0]  op_sel,
  input  logic [CNT_W-1:0] n,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] idx_inc;

  // idx never exceeds n_q-1 in RUN, so idx_inc cannot wrap
  assign idx_inc = idx_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      prev_q   <= '0;
      cur_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      n_q      <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cur_q    <= cur_d;
      result_q <= result_d;
      op_q     <= op_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    cur_d    = cur_q;
    result_d = result_q;
    op_d     = op_q;
    n_d      = n_q;
    idx_d    = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          prev_d = seed0;
          cur_d  = seed1;
          op_d   = op_sel;
          n_d    = n;
          idx_d  = CNT_W'(1);
          if (n == '0) begin
            result_d = seed0;
            state_d  = ST_DONE;
          end else if (n == CNT_W'(1)) begin
            result_d = seed1;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        prev_d = cur_q;
        cur_d  = alu_out;
        idx_d  = idx_inc;
        if (idx_inc == n_q) begin
          result_d = alu_out;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands stay visible outside RUN; only the opcode is parked at zero
  assign alu_a  = cur_q;
  assign alu_b  = prev_q;
  assign alu_op = (state_q == ST_RUN) ? op_q : '0;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule : alu_seq_ctrl
`default_nettype wire

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequential initiator on the ALU operand/op/result interface.
- Drives alu_a, alu_b and alu_op each cycle and captures alu_out, generating a recurrence sequence: term0 = seed0, term1 = seed1, termk = term(k-1) OP term(k-2).
- Returns term n with a done pulse.
- Sits beside the combinational ALU in the lab datapath; the lab top connects its ALU-side ports to the ALU.

Parameters:
- WIDTH, 32, data width of seeds, operands, result (matches ALU).
- OP_W, 5, width of ALU opcode.
- CNT_W, 8, width of term index n.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- seed0  in  WIDTH  term 0, latched on accepted start
- seed1  in  WIDTH  term 1, latched on accepted start
- op_sel  in  OP_W  ALU opcode used for every step, latched on start
- n  in  CNT_W  index of requested term, latched on start
- alu_a  out  WIDTH  operand A to ALU, driven from r_cur (term k-1)
- alu_b  out  WIDTH  operand B to ALU, driven from r_prev (term k-2)
- alu_op  out  OP_W  latched op_sel; 0 outside RUN
- alu_out  in  WIDTH  combinational ALU result, same cycle
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; result valid from this cycle
- result  out  WIDTH  term n; holds until next accepted start

Behaviour:
- Reset (async, any state, including mid-run):
  - state = IDLE.
  - r_prev, r_cur, idx, n_q, op_q and result = 0.
  - alu_a, alu_b, alu_op, busy and done = 0.
  - No done pulse for an aborted run.
- States: IDLE, RUN, DONE (shared-package encoding).
- IDLE with start=1 at edge E0:
  - Latch r_prev = seed0, r_cur = seed1, op_q = op_sel, n_q = n, idx = 1.
  - n == 0: go to DONE, result = seed0.
  - n == 1: go to DONE, result = seed1.
  - Otherwise go to RUN.
- RUN, each edge:
  - r_prev <= r_cur, r_cur <= alu_out, idx <= idx+1.
  - If idx+1 == n_q: result <= alu_out, go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - n >= 2: done is high in the cycle after edge E0+(n-1), i.e. n-1 RUN cycles.
  - n <= 1: done is high in the cycle after E0.
- start while busy is ignored; latched inputs are unaffected.
- start in DONE is ignored; a new run can start from the next IDLE cycle.
- Back-to-back throughput: one request per n+1 cycles (n >= 2).
- Arithmetic: all results are taken from alu_out unmodified; wrap-around and overflow follow ALU semantics (mod 2^WIDTH). The block does no arithmetic of its own beyond the idx increment.
- idx width is CNT_W; n = 2^CNT_W-1 is reached without idx overflow.
- alu_a and alu_b keep their last register values in IDLE and DONE; only alu_op is forced to 0 there.

Decomposition:
- Shared package holds:
  - ALU opcode constants: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, remaining ops per ALU table.
  - FSM state encoding for IDLE, RUN, DONE.
  - WIDTH and OP_W defaults.
- No internal sub-module. Natural companion top: alu_seq_top, which instantiates alu_seq_ctrl plus the ALU and wires alu_a/alu_b/alu_op/alu_out.

Test Plan:
- seed0=1, seed1=1, op=ADD, n=10 -> done 9 cycles after start edge; result=89; alu_a sequence 1,2,3,5,8,13,21,34,55.
- n=0 with seed0=0x1234 -> done the cycle after start; result=0x1234. n=1 with seed1=0xBEEF -> result=0xBEEF.
- seed0=0xFFFFFFFF, seed1=1, op=ADD, n=2 -> result=0x00000000 (wrap); then seed0=10, seed1=7, op=SUB, n=2 -> result=0xFFFFFFFD.
- Start with n=5, assert start again with different seeds during RUN -> ignored; result equals term 5 of the first seeds; one done pulse only.
- Assert rst for 1 cycle mid-RUN (n=20, after 4 steps) -> all outputs 0 immediately (async); no done; fresh start with n=3, seeds 2,3, ADD -> result=8.
- Two runs back-to-back with start held high -> second run accepted on the first IDLE cycle after DONE; result updates only at the second done.
